// File: rtl/av1_obu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : av1_obu_pkg
// Description : Shared AV1 OBU types, parser FSM states and size constants.
// Revision    : 1.0 - initial release
// ============================================================================
package av1_obu_pkg;

    localparam int SIZE_W        = 56;
    localparam int MAX_LEB_BYTES = 8;

    typedef enum logic [3:0] {
        OBU_SEQUENCE_HEADER        = 4'd1,
        OBU_TEMPORAL_DELIMITER     = 4'd2,
        OBU_FRAME_HEADER           = 4'd3,
        OBU_TILE_GROUP             = 4'd4,
        OBU_METADATA               = 4'd5,
        OBU_FRAME                  = 4'd6,
        OBU_REDUNDANT_FRAME_HEADER = 4'd7,
        OBU_TILE_LIST              = 4'd8,
        OBU_PADDING                = 4'd15
    } obu_type_e;

    typedef enum logic [2:0] {
        ST_HDR     = 3'd0,
        ST_EXT     = 3'd1,
        ST_SIZE    = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_ERROR   = 3'd4
    } obu_state_e;

endpackage
`default_nettype wire

// File: rtl/obu_header_parser_if.sv
`default_nettype none
// ============================================================================
// Module      : obu_header_parser_if
// Description : Byte stream with valid/ready handshake and end marker.
// Revision    : 1.0 - initial release
// ============================================================================
interface obu_header_parser_if;
    logic       valid;
    logic [7:0] data;
    logic       last;
    logic       ready;

    modport master (output valid, output data, output last, input  ready);
    modport slave  (input  valid, input  data, input  last, output ready);
endinterface
`default_nettype wire

// File: rtl/obu_header_parser_leb128.sv
`default_nettype none
// ============================================================================
// Module      : leb128_parser
// Description : LEB128 obu_size decoder; data_out/done/overflow reflect the
//               byte currently presented, so the caller can act in that cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module leb128_parser
    import av1_obu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              valid,
    input  logic [7:0]        data,
    output logic [SIZE_W-1:0] data_out,
    output logic              done,
    output logic              overflow
);
    localparam int c_IDX_W = $clog2(MAX_LEB_BYTES);

    logic [SIZE_W-1:0]  r_acc;
    logic [c_IDX_W-1:0] r_idx;
    logic [SIZE_W-1:0]  w_base;
    logic [c_IDX_W-1:0] w_idx;
    logic [5:0]         w_shamt;

    // start substitutes a cleared accumulator so the first byte needs no extra cycle
    always_comb begin
        w_base   = start ? '0 : r_acc;
        w_idx    = start ? '0 : r_idx;
        w_shamt  = 6'(w_idx) * 6'd7;
        data_out = w_base | (SIZE_W'(data[6:0]) << w_shamt);
        done     = valid & ~data[7];
        overflow = valid & data[7] & (w_idx == c_IDX_W'(MAX_LEB_BYTES - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_idx <= '0;
        end else if (valid) begin
            r_acc <= data_out;
            r_idx <= w_idx + c_IDX_W'(1);
        end
    end
endmodule
`default_nettype wire

// File: rtl/obu_header_parser.sv
`default_nettype none
// ============================================================================
// Module      : obu_header_parser
// Description : Parses AV1 OBU headers and passes the payload through.
// Revision    : 1.0 - initial release
// ============================================================================
module obu_header_parser
    import av1_obu_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    obu_header_parser_if.slave  in_if,
    obu_header_parser_if.master pl_if,
    output logic                hdr_valid,
    output logic [3:0]          obu_type,
    output logic                has_ext,
    output logic                has_size,
    output logic [2:0]          temporal_id,
    output logic [1:0]          spatial_id,
    output logic [SIZE_W-1:0]   obu_size,
    output logic                err
);
    obu_state_e r_state, w_state_next;

    logic [3:0]        r_hdr_type;
    logic              r_hdr_ext, r_hdr_size;
    logic [2:0]        r_ext_tid;
    logic [1:0]        r_ext_sid;
    logic              r_leb_first;
    logic [SIZE_W-1:0] r_remaining;
    logic              r_hdr_valid, r_err;
    logic [3:0]        r_obu_type;
    logic              r_has_ext, r_has_size;
    logic [2:0]        r_temporal_id;
    logic [1:0]        r_spatial_id;
    logic [SIZE_W-1:0] r_obu_size;

    logic              w_in_ready, w_pl_valid, w_pl_last;
    logic              w_accept, w_publish, w_fault;
    logic              w_leb_valid, w_leb_done, w_leb_overflow;
    logic [SIZE_W-1:0] w_leb_size;
    logic [3:0]        w_pub_type;
    logic              w_pub_ext, w_pub_has_size;
    logic [2:0]        w_pub_tid;
    logic [1:0]        w_pub_sid;
    logic [SIZE_W-1:0] w_pub_size;

    assign w_leb_valid = (r_state == ST_SIZE) && in_if.valid;

    leb128_parser u_leb128 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (r_leb_first),
        .valid    (w_leb_valid),
        .data     (in_if.data),
        .data_out (w_leb_size),
        .done     (w_leb_done),
        .overflow (w_leb_overflow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_HDR;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_pl_valid   = 1'b0;
        w_pl_last    = 1'b0;
        w_accept     = 1'b0;
        w_publish    = 1'b0;
        w_fault      = 1'b0;
        case (r_state)
            ST_HDR: begin
                w_in_ready = 1'b1;
                w_accept   = in_if.valid;
                if (w_accept) begin
                    if (in_if.data[7] || in_if.last) w_fault = 1'b1;
                    else if (in_if.data[2])          w_state_next = ST_EXT;
                    else if (in_if.data[1])          w_state_next = ST_SIZE;
                    else begin
                        w_publish    = 1'b1;
                        w_state_next = ST_PAYLOAD;
                    end
                end
            end
            ST_EXT: begin
                w_in_ready = 1'b1;
                w_accept   = in_if.valid;
                if (w_accept) begin
                    if (in_if.last)      w_fault = 1'b1;
                    else if (r_hdr_size) w_state_next = ST_SIZE;
                    else begin
                        w_publish    = 1'b1;
                        w_state_next = ST_PAYLOAD;
                    end
                end
            end
            ST_SIZE: begin
                w_in_ready = 1'b1;
                w_accept   = in_if.valid;
                if (w_accept) begin
                    if (in_if.last || w_leb_overflow) w_fault = 1'b1;
                    else if (w_leb_done) begin
                        w_publish    = 1'b1;
                        w_state_next = (w_leb_size == '0) ? ST_HDR : ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                w_in_ready = pl_if.ready;
                w_pl_valid = in_if.valid;
                w_pl_last  = r_hdr_size ? (r_remaining == SIZE_W'(1)) : in_if.last;
                w_accept   = in_if.valid && pl_if.ready;
                if (w_accept) begin
                    if (r_hdr_size) begin
                        if (r_remaining == SIZE_W'(1)) w_state_next = ST_HDR;
                        else if (in_if.last)           w_fault = 1'b1;
                    end else if (in_if.last) begin
                        w_state_next = ST_HDR;
                    end
                end
            end
            ST_ERROR: begin
                w_state_next = ST_ERROR;
            end
            default: w_state_next = ST_ERROR;
        endcase
        if (w_fault) w_state_next = ST_ERROR;
    end

    // Field values published by whichever byte ends the header
    always_comb begin
        w_pub_type     = r_hdr_type;
        w_pub_ext      = r_hdr_ext;
        w_pub_has_size = r_hdr_size;
        w_pub_tid      = r_ext_tid;
        w_pub_sid      = r_ext_sid;
        w_pub_size     = '0;
        case (r_state)
            ST_HDR: begin
                w_pub_type     = in_if.data[6:3];
                w_pub_ext      = in_if.data[2];
                w_pub_has_size = in_if.data[1];
                w_pub_tid      = '0;
                w_pub_sid      = '0;
            end
            ST_EXT: begin
                w_pub_tid = in_if.data[7:5];
                w_pub_sid = in_if.data[4:3];
            end
            ST_SIZE: w_pub_size = w_leb_size;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hdr_type    <= '0;
            r_hdr_ext     <= 1'b0;
            r_hdr_size    <= 1'b0;
            r_ext_tid     <= '0;
            r_ext_sid     <= '0;
            r_leb_first   <= 1'b0;
            r_remaining   <= '0;
            r_hdr_valid   <= 1'b0;
            r_err         <= 1'b0;
            r_obu_type    <= '0;
            r_has_ext     <= 1'b0;
            r_has_size    <= 1'b0;
            r_temporal_id <= '0;
            r_spatial_id  <= '0;
            r_obu_size    <= '0;
        end else begin
            r_hdr_valid <= w_publish;
            if (w_fault) r_err <= 1'b1;
            if (r_state == ST_HDR && w_accept) begin
                r_hdr_type <= in_if.data[6:3];
                r_hdr_ext  <= in_if.data[2];
                r_hdr_size <= in_if.data[1];
                r_ext_tid  <= '0;
                r_ext_sid  <= '0;
            end
            if (r_state == ST_EXT && w_accept) begin
                r_ext_tid <= in_if.data[7:5];
                r_ext_sid <= in_if.data[4:3];
            end
            if (w_state_next == ST_SIZE && r_state != ST_SIZE) r_leb_first <= 1'b1;
            else if (w_leb_valid)                               r_leb_first <= 1'b0;
            if (w_publish) begin
                r_obu_type    <= w_pub_type;
                r_has_ext     <= w_pub_ext;
                r_has_size    <= w_pub_has_size;
                r_temporal_id <= w_pub_tid;
                r_spatial_id  <= w_pub_sid;
                r_obu_size    <= w_pub_size;
                r_remaining   <= w_pub_size;
            end else if (r_state == ST_PAYLOAD && w_accept && r_hdr_size) begin
                r_remaining <= r_remaining - SIZE_W'(1);
            end
        end
    end

    assign in_if.ready = w_in_ready;
    assign pl_if.valid = w_pl_valid;
    assign pl_if.data  = in_if.data;
    assign pl_if.last  = w_pl_last;
    assign hdr_valid   = r_hdr_valid;
    assign obu_type    = r_obu_type;
    assign has_ext     = r_has_ext;
    assign has_size    = r_has_size;
    assign temporal_id = r_temporal_id;
    assign spatial_id  = r_spatial_id;
    assign obu_size    = r_obu_size;
    assign err         = r_err;
endmodule
`default_nettype wire

// File: doc/obu_header_parser.md
# obu_header_parser

Byte-stream front end of the AV1 bitstream decoder. Accepts raw bitstream bytes and parses each OBU header: the header byte, the optional extension byte and the LEB128 `obu_size` field. It publishes the header fields with a single-cycle strobe, then forwards exactly `obu_size` payload bytes downstream with a last-byte marker. It sits between the input byte FIFO and the per-OBU-type parsers.

## Interface
- `SIZE_W`, 56: width of the decoded `obu_size`.
- `MAX_LEB_BYTES`, 8: maximum number of bytes in the size field.

- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  input byte valid
- `in_data`  in  8  input byte
- `in_last`  in  1  final byte of the current temporal unit
- `in_ready`  out  1  input byte accepted when `in_valid & in_ready`
- `hdr_valid`  out  1  one-cycle strobe: header fields valid
- `obu_type`  out  4  header bits [6:3]
- `has_ext`  out  1  header bit 2
- `has_size`  out  1  header bit 1
- `temporal_id`  out  3  extension bits [7:5]; 0 if no extension
- `spatial_id`  out  2  extension bits [4:3]; 0 if no extension
- `obu_size`  out  SIZE_W  decoded size; 0 if `has_size` = 0
- `pl_valid`  out  1  payload byte valid
- `pl_data`  out  8  payload byte
- `pl_last`  out  1  final payload byte of the OBU
- `pl_ready`  in  1  downstream accepts the payload byte
- `err`  out  1  sticky protocol error

## Operation
- FSM states and transitions:
  - HDR → EXT if header bit 2 is set.
  - HDR → SIZE if bit 2 is clear and bit 1 is set.
  - HDR → PAYLOAD otherwise.
  - EXT → SIZE if `has_size`, otherwise → PAYLOAD.
  - SIZE → PAYLOAD when a byte with bit 7 = 0 is accepted. If the decoded size is 0, SIZE goes to HDR instead.
  - PAYLOAD → HDR on acceptance of the `pl_last` byte.
  - Any state → ERROR on a fault. ERROR exits only through reset.
- The header byte is latched in full. Forbidden bit 7 = 1 is a fault. Reserved bit 0 is ignored.
- Extension reserved bits [2:0] are ignored.
- LEB128 size field:
  - Byte i (i = 0..7) ORs `data[6:0] << 7i` into the accumulator. The accumulator is cleared on entry to SIZE.
  - Continuation set on byte 8 (i = 7) is a fault. Maximum value is 2^56−1.
- PAYLOAD with `has_size` = 1:
  - A down-counter is loaded with `obu_size` and decremented on each accepted byte.
  - `pl_last` = (remaining == 1).
- PAYLOAD with `has_size` = 0: payload runs until the `in_last` byte, and `pl_last` = `in_last`.
- `in_last` on any HDR, EXT or SIZE byte is a fault. `in_last` on a sized payload byte other than the last is a fault; that byte is still forwarded.
- In ERROR: `in_ready` = 0, `pl_valid` = 0, `err` = 1.
- Header fields hold their values until the next `hdr_valid`.

## Timing
- Reset values: `in_ready` = 1, `hdr_valid` = 0, `err` = 0, all fields 0, `pl_valid` = 0, `pl_last` = 0, state HDR.
- `in_ready` = 1 in HDR, EXT and SIZE: one header byte is consumed per cycle, with no backpressure.
- `hdr_valid` pulses for exactly one cycle, in the cycle after the final header byte is accepted. The final header byte is the header byte, the extension byte or the last size byte, whichever ends the header.
- That cycle is also the first PAYLOAD cycle, so a payload byte may transfer in it. For a zero-size OBU the pulse occurs in HDR, and the next header byte may be accepted in the same cycle.
- Header latency: N header bytes → `hdr_valid` at cycle N+1 relative to the first accepted byte.
- PAYLOAD is combinational pass-through:
  - `pl_valid` = `in_valid`, `pl_data` = `in_data`, `in_ready` = `pl_ready`.
  - Zero added latency, one byte per cycle at full throughput.
- `err` rises in the cycle after the faulting byte is accepted.
- Reset asserted mid-OBU aborts immediately: all state returns to reset values and the partial header is discarded.

## Structure
- Shared package `av1_obu_pkg`:
  - `obu_type_e` enum: `OBU_SEQUENCE_HEADER` = 1, `OBU_TEMPORAL_DELIMITER` = 2, `OBU_FRAME_HEADER` = 3, `OBU_TILE_GROUP` = 4, `OBU_METADATA` = 5, `OBU_FRAME` = 6, `OBU_REDUNDANT_FRAME_HEADER` = 7, `OBU_TILE_LIST` = 8, `OBU_PADDING` = 15.
  - FSM state enum.
  - `SIZE_W` and `MAX_LEB_BYTES` constants.
- One natural sub-module, `leb128_parser`, decodes the size field. It uses `start` on the first size byte, `data_out` as the size and `done` on the terminal byte. The byte-8 overflow check stays in this block.

## Test plan
- Bytes 0x12 0x00 → `hdr_valid`; type = 2 (temporal delimiter), `obu_size` = 0; no `pl_valid`; state returns to HDR.
- Bytes 0x0A 0x03 0xAA 0xBB 0xCC → type = 1, `obu_size` = 3; payload AA, BB, CC with `pl_last` only on CC.
- Bytes 0x36 0x68 0x80 0x01 followed by 128 payload bytes → `has_ext` = 1, `temporal_id` = 3, `spatial_id` = 1, type = 6, `obu_size` = 128. Toggle `pl_ready` randomly; all 128 bytes are delivered in order.
- Bytes 0x30 followed by 5 bytes with `in_last` on the 5th → `has_size` = 0, `obu_size` = 0, 5 payload bytes, `pl_last` on the 5th.
- Header byte 0x8A → `err` = 1 and `in_ready` = 0 from the next cycle; they stay that way until `rst_n` pulses.
- Bytes 0x0A followed by eight 0xFF size bytes → `err`. Separately, 0x0A 0xFF×7 0x7F → `obu_size` = 2^56−1 with no `err`. Assert `rst_n` while payload is streaming → all outputs return to reset values and the next header byte parses cleanly.
